// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host frame receiver with glitch-filtered clock
// Optional intra-frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy,
  output logic       timeout_tick
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DPS  = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t state, state_next;

  logic                  c_s1, c_s2, d_s1, d_s2;
  logic [FILTER_LEN-1:0] filt;
  logic                  f_val, f_next, fall_edg;
  logic [3:0]            n;
  logic [9:0]            b, b_shift;
  logic                  start_ok, wd_expire;

  // Reset to all ones so the filtered clock sees no edge on reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_s1  <= 1'b1;
      c_s2  <= 1'b1;
      d_s1  <= 1'b1;
      d_s2  <= 1'b1;
      filt  <= {FILTER_LEN{1'b1}};
      f_val <= 1'b1;
    end else begin
      c_s1  <= ps2c;
      c_s2  <= c_s1;
      d_s1  <= ps2d;
      d_s2  <= d_s1;
      filt  <= {filt[FILTER_LEN-2:0], c_s2};
      f_val <= f_next;
    end
  end

  always_comb begin
    f_next = f_val;
    if (filt == {FILTER_LEN{1'b1}})
      f_next = 1'b1;
    else if (filt == {FILTER_LEN{1'b0}})
      f_next = 1'b0;
  end

  assign fall_edg = f_val & ~f_next;
  assign b_shift  = {d_s2, b[9:1]};
  assign start_ok = fall_edg & ~d_s2 & rx_en;

`ifdef PS2_RX_TIMEOUT_EN
  localparam logic [16:0] WD_MAX = 17'(TIMEOUT_CYCLES - 1);
  logic [16:0] wd;

  always_ff @(posedge clk) begin
    if (rst || state != DPS || fall_edg)
      wd <= 17'd0;
    else
      wd <= wd + 17'd1;
  end

  assign wd_expire = (state == DPS) && !fall_edg && (wd == WD_MAX);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_ok) state_next = DPS;
      DPS: begin
        if (fall_edg && n == 4'd9)
          state_next = LOAD;
        else if (wd_expire)
          state_next = IDLE;
      end
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rx_busy      = 1'b0;
    rx_done_tick = 1'b0;
    timeout_tick = 1'b0;
    case (state)
      DPS: begin
        rx_busy      = 1'b1;
        timeout_tick = wd_expire;
      end
      LOAD: begin
        rx_busy      = 1'b1;
        rx_done_tick = 1'b1;
      end
      default: ;
    endcase
  end

  // Result registers are captured on the stop edge so they are valid alongside the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      n          <= 4'd0;
      b          <= 10'd0;
      dout       <= 8'd0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (state == IDLE && start_ok)
        n <= 4'd0;
      if (state == DPS && fall_edg) begin
        b <= b_shift;
        if (n != 4'd9) begin
          n <= n + 4'd1;
        end else begin
          dout       <= b_shift[7:0];
          parity_err <= ~^b_shift[8:0];
          frame_err  <= ~b_shift[9];
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - randomized self-checking bench for ps2_rx
// Watchdog checks follow PS2_RX_TIMEOUT_EN when it is defined.
module tb_ps2_rx;

  localparam int TO = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_en = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick, parity_err, frame_err, rx_busy, timeout_tick;

  ps2_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_en        (rx_en),
    .ps2c         (ps2c),
    .ps2d         (ps2d),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .rx_busy      (rx_busy),
    .timeout_tick (timeout_tick)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc_cnt = 0;
  int         tick_cnt = 0;
  int         to_cnt = 0;
  int         to_cycle = 0;
  int         fall_cycle = 0;
  bit         busy_seen = 0;
  logic [7:0] cap_dout = 8'd0;
  logic       cap_perr = 1'b0;
  logic       cap_ferr = 1'b0;
  int         half = 30;

  always @(posedge clk) cyc_cnt++;

  always @(negedge clk) begin
    if (rx_busy) busy_seen = 1;
    if (rx_done_tick) begin
      tick_cnt++;
      cap_dout = dout;
      cap_perr = parity_err;
      cap_ferr = frame_err;
    end
    if (timeout_tick) begin
      to_cnt++;
      to_cycle = cyc_cnt;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // bits[0] is the start bit; a glitch is injected into the high phase of edge 4.
  task automatic send_frame(input logic [10:0] bits, input int nedges, input bit glitch);
    for (int i = 0; i < nedges; i++) begin
      ps2d = bits[i];
      cyc(half / 2);
      ps2c = 1'b0;
      fall_cycle = cyc_cnt;
      cyc(half);
      ps2c = 1'b1;
      if (glitch && i == 4) begin
        cyc(6);
        ps2c = 1'b0;
        cyc(5);
        ps2c = 1'b1;
        cyc(half - 11);
      end else begin
        cyc(half);
      end
    end
    ps2d = 1'b1;
  endtask

  function automatic logic [10:0] mk_bits(input logic [7:0] data, input logic par, input logic stop);
    return {stop, par, data, 1'b0};
  endfunction

  task automatic run_frame(input string tag, input logic [7:0] data, input logic par,
                           input logic stop, input bit glitch);
    int t0;
    t0   = tick_cnt;
    half = $urandom_range(24, 40);
    send_frame(mk_bits(data, par, stop), 11, glitch);
    cyc(30);
    chk({tag, "_ticks"}, 32'(tick_cnt - t0), 32'd1);
    chk({tag, "_dout"}, {24'd0, cap_dout}, {24'd0, data});
    chk({tag, "_perr"}, {31'd0, cap_perr}, {31'd0, ($countones({data, par}) % 2) == 0});
    chk({tag, "_ferr"}, {31'd0, cap_ferr}, {31'd0, ~stop});
    chk({tag, "_hold"}, {24'd0, dout}, {24'd0, data});
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "tb_ps2_rx stalled");
  end

  initial begin
    int t0;
    int k0;
    cyc(5);
    rst = 1'b0;
    cyc(20);
    @(negedge clk);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    chk("rst_flags", {30'd0, parity_err, frame_err}, 32'd0);
    chk("rst_ticks", 32'(tick_cnt + to_cnt), 32'd0);
    cyc(1);

    run_frame("a5", 8'hA5, 1'b1, 1'b1, 1'b0);
    run_frame("3c", 8'h3C, 1'b0, 1'b0, 1'b0);
    run_frame("1c", 8'h1C, 1'b0, 1'b1, 1'b0);

    t0 = tick_cnt;
    busy_seen = 0;
    for (int g = 0; g < 6; g++) begin
      ps2c = 1'b0;
      ps2d = g[0];
      cyc(5);
      ps2c = 1'b1;
      cyc($urandom_range(12, 30));
    end
    ps2d = 1'b1;
    cyc(20);
    chk("glitch_idle_ticks", 32'(tick_cnt - t0), 32'd0);
    chk("glitch_idle_busy", {31'd0, busy_seen}, 32'd0);
    run_frame("55g", 8'h55, 1'b1, 1'b1, 1'b1);

    rx_en = 1'b0;
    t0 = tick_cnt;
    busy_seen = 0;
    send_frame(mk_bits(8'hF0, 1'b1, 1'b1), 11, 1'b0);
    cyc(30);
    chk("dis_ticks", 32'(tick_cnt - t0), 32'd0);
    chk("dis_busy", {31'd0, busy_seen}, 32'd0);
    rx_en = 1'b1;
    run_frame("12", 8'h12, 1'b1, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      logic [7:0] data;
      logic       par, stop;
      data = 8'($urandom);
      par  = 1'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rnd%0d", r), data, par, stop, 1'($urandom_range(0, 1)));
    end

    k0 = to_cnt;
    half = 30;
    send_frame(mk_bits(8'h1C, 1'b0, 1'b1), 5, 1'b0);
`ifdef PS2_RX_TIMEOUT_EN
    for (int w = 0; w < TO + 200 && to_cnt == k0; w++) cyc(1);
    chk("to_pulse", 32'(to_cnt - k0), 32'd1);
    chk("to_latency", {31'd0, (to_cycle - fall_cycle) >= TO + 8 && (to_cycle - fall_cycle) <= TO + 12}, 32'd1);
    cyc(5);
    chk("to_busy", {31'd0, rx_busy}, 32'd0);
    chk("to_dout", {24'd0, dout}, {24'd0, cap_dout});
`else
    cyc(TO + 200);
    chk("to_none", 32'(to_cnt - k0), 32'd0);
    chk("to_busy_held", {31'd0, rx_busy}, 32'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(5);
`endif
    run_frame("1c_after", 8'h1C, 1'b0, 1'b1, 1'b0);

    t0 = tick_cnt;
    half = 30;
    send_frame(mk_bits(8'h7E, 1'b1, 1'b1), 6, 1'b0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_dout", {24'd0, dout}, 32'd0);
    chk("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
    chk("mid_rst_flags", {30'd0, parity_err, frame_err}, 32'd0);
    cyc(20);
    chk("mid_rst_ticks", 32'(tick_cnt - t0), 32'd0);
    run_frame("7e", 8'h7E, 1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

Receives device-to-host PS/2 frames (keyboard/mouse scan codes) on the `ps2c`/`ps2d` lines and presents each byte with a one-cycle done tick plus parity and framing status. It is the receive half of the PS/2 port; it shares the bus with the host transmitter, whose idle status drives `rx_en`. The block only observes the lines and never drives them.

## Interface
- `FILTER_LEN`, 8: depth of the ps2c glitch-filter shift register, in clk cycles.
- `TIMEOUT_CYCLES`, 100000: max clk cycles allowed between falling edges inside a frame (2 ms at 50 MHz).
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_en`  in  1  enables detection of a new start bit; tie to transmitter idle.
- `ps2c`  in  1  raw PS/2 clock pin (asynchronous).
- `ps2d`  in  1  raw PS/2 data pin (asynchronous).
- `dout`  out  8  last received byte; held until the next completed frame.
- `rx_done_tick`  out  1  one-cycle pulse per completed frame.
- `parity_err`  out  1  odd-parity failure of the last frame; updated with `rx_done_tick`.
- `frame_err`  out  1  stop bit was 0 in the last frame; updated with `rx_done_tick`.
- `rx_busy`  out  1  high while a frame is in progress.
- `timeout_tick`  out  1  one-cycle pulse when an incomplete frame is aborted.

## Operation
- `ps2c` and `ps2d` each pass through a 2-flop synchronizer. Synchronized `ps2c` shifts into a `FILTER_LEN`-bit register. The filtered clock becomes 1 when the register is all ones, 0 when all zeros, and otherwise holds.
- `fall_edg` = filtered clock is 1 now and its next value is 0. Data is sampled as the synchronized `ps2d` in the `fall_edg` cycle.
- Frame: start(0), d0..d7 (LSB first), parity (odd), stop(1). That is 11 falling edges.
- FSM states:
  - `idle`: `rx_busy`=0. On `fall_edg` with sampled data 0 and `rx_en`=1, clear the bit counter n and go to `dps`. A start edge with data 1 or `rx_en`=0 is ignored.
  - `dps`: `rx_busy`=1. On each `fall_edg`, shift the sampled bit into the MSB of a 10-bit shift register b. If n==9, go to `load`; otherwise n++.
  - `load`: `rx_busy`=1. Set `dout`=b[7:0]. Set `parity_err` = ~^b[8:0], which is 1 when the total count of ones across data and parity is even. Set `frame_err` = ~b[9]. Pulse `rx_done_tick` and return to `idle`.
- `rx_en` only gates the start of a frame. Deasserting it mid-frame does not abort the frame.
- An invalid state encoding returns to `idle`.

## Timing
- Reset values:
  - all outputs 0, FSM in `idle`, n=0, b=0;
  - synchronizers and filter all ones, filtered clock 1, so reset release produces no spurious edge.
- Edge latency: `fall_edg` asserts exactly 2+`FILTER_LEN` cycles (10 at default) after raw `ps2c` is first sampled low, provided `ps2c` stays low. Any low pulse shorter than `FILTER_LEN` cycles produces no edge.
- Frame latency:
  - The `fall_edg` for the stop bit moves the FSM to `load`.
  - `rx_done_tick`, `dout`, `parity_err` and `frame_err` all update in the following cycle.
  - `rx_busy` falls in the cycle after that.
- Back-to-back frames: `load` lasts one cycle, so a start edge arriving in the cycle immediately after `load` is accepted.
- Reset asserted mid-frame: the FSM returns to `idle` on the next clk edge, with no tick and no error flags.

## Configuration
- `PS2_RX_TIMEOUT_EN` defined:
  - A 17-bit watchdog counter clears on entry to `dps` and on every `fall_edg`, and increments otherwise while in `dps`.
  - When it reaches `TIMEOUT_CYCLES`-1, the FSM returns to `idle` and `timeout_tick` pulses for 1 cycle.
  - `dout` and the error flags are unchanged.
- `PS2_RX_TIMEOUT_EN` undefined: no counter is built, `timeout_tick` is tied to 0, and a partial frame waits indefinitely.

## Test plan
- Valid frame 0xA5 with parity 1 and stop 1 (ps2c period 80 µs) -> exactly one `rx_done_tick`, `dout`=0xA5, `parity_err`=0, `frame_err`=0.
- Frame 0x3C with parity 0 and stop 0 -> `dout`=0x3C, `parity_err`=1, `frame_err`=1. A following valid frame 0x1C clears both flags.
- 5-cycle low glitches on ps2c while idle, plus one glitch inside a valid 0x55 frame -> no extra edges, `dout`=0x55, a single tick.
- `rx_en`=0 during a 0xF0 frame -> no tick, `rx_busy` stays 0. Then `rx_en`=1 and frame 0x12 -> `dout`=0x12.
- With `PS2_RX_TIMEOUT_EN`: send start + 4 bits, then stop toggling -> `timeout_tick` pulses 100000 cycles after the last edge. The next frame 0x1C is received correctly. Without the macro: no tick, `rx_busy` stays 1.
- Assert `rst` for 1 cycle after the 6th edge of a frame -> all outputs 0. A subsequent frame 0x7E is received correctly.
